// File: rtl/mult_unit.sv
// Iterative shift-add multiplier for MULT/MULTU that owns the HI/LO registers.
// Retires BITS_PER_CYCLE multiplier bits per BUSY cycle and writes HI/LO in one DONE cycle.
module mult_unit #(
    parameter int WIDTH          = 32,
    parameter int BITS_PER_CYCLE = 1
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             multstartE,
    input  logic             signedE,
    input  logic [WIDTH-1:0] srcaE,
    input  logic [WIDTH-1:0] srcbE,
    input  logic             hiwriteE,
    input  logic             lowriteE,
    input  logic [WIDTH-1:0] wdataE,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo,
    output logic             pve,
    output logic             busy
);

    localparam int AW    = 2 * WIDTH;
    localparam int PW    = WIDTH + BITS_PER_CYCLE;
    localparam int STEPS = WIDTH / BITS_PER_CYCLE;
    localparam int CW    = $clog2(STEPS + 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_BUSY,
        S_DONE
    } state_t;

    state_t           r_state;
    logic [AW-1:0]    r_acc;
    logic [WIDTH-1:0] r_mcand;
    logic [WIDTH-1:0] r_mplier;
    logic [CW-1:0]    r_count;
    logic             r_sign;
    logic [WIDTH-1:0] r_hi;
    logic [WIDTH-1:0] r_lo;
    logic             r_pve;
    logic             r_busy;

    logic [WIDTH-1:0] w_absA;
    logic [WIDTH-1:0] w_absB;
    logic [PW-1:0]    w_partial;
    logic [PW-1:0]    w_sum;
    logic [AW-1:0]    w_result;

    // Magnitudes of the operands; the most-negative value maps onto 2^(WIDTH-1) unsigned.
    assign w_absA = (signedE && srcaE[WIDTH-1]) ? (~srcaE + WIDTH'(1)) : srcaE;
    assign w_absB = (signedE && srcbE[WIDTH-1]) ? (~srcbE + WIDTH'(1)) : srcbE;

    // Upper half plus one partial product cannot exceed PW bits, so no carry is lost.
    assign w_partial = PW'(r_mcand) * PW'(r_mplier[BITS_PER_CYCLE-1:0]);
    assign w_sum     = PW'(r_acc[AW-1:WIDTH]) + w_partial;
    assign w_result  = r_sign ? (~r_acc + AW'(1)) : r_acc;

    assign hi   = r_hi;
    assign lo   = r_lo;
    assign pve  = r_pve;
    assign busy = r_busy;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state  <= S_IDLE;
            r_acc    <= '0;
            r_mcand  <= '0;
            r_mplier <= '0;
            r_count  <= '0;
            r_sign   <= 1'b0;
            r_hi     <= '0;
            r_lo     <= '0;
            r_pve    <= 1'b1;
            r_busy   <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (hiwriteE) r_hi <= wdataE;
                    if (lowriteE) r_lo <= wdataE;
                    if (multstartE) begin
                        r_mcand  <= w_absA;
                        r_mplier <= w_absB;
                        r_sign   <= signedE & (srcaE[WIDTH-1] ^ srcbE[WIDTH-1]);
                        r_acc    <= '0;
                        r_count  <= CW'(STEPS);
                        r_pve    <= 1'b0;
                        r_busy   <= 1'b1;
                        r_state  <= S_BUSY;
                    end
                end
                S_BUSY: begin
                    if (r_count != '0) begin
                        r_acc    <= {w_sum, r_acc[WIDTH-1:BITS_PER_CYCLE]};
                        r_mplier <= r_mplier >> BITS_PER_CYCLE;
                        r_count  <= r_count - CW'(1);
                    end else begin
                        r_state <= S_DONE;
                    end
                end
                S_DONE: begin
                    r_hi    <= w_result[AW-1:WIDTH];
                    r_lo    <= w_result[WIDTH-1:0];
                    r_pve   <= 1'b1;
                    r_busy  <= 1'b0;
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                    r_pve   <= 1'b1;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mult_unit.sv
// Scoreboard bench for mult_unit: a 1-bit/cycle instance plus a 4-bit/cycle instance.
// Expected products come from a 64-bit arithmetic model queued at start time.
module tb_mult_unit;

    logic        clk;
    logic        reset_n;
    logic        multstartE;
    logic        start4;
    logic        signedE;
    logic [31:0] srcaE;
    logic [31:0] srcbE;
    logic        hiwriteE;
    logic        lowriteE;
    logic [31:0] wdataE;
    logic [31:0] hi;
    logic [31:0] lo;
    logic        pve;
    logic        busy;
    logic [31:0] hi4;
    logic [31:0] lo4;
    logic        pve4;
    logic        busy4;

    int checks = 0;
    int errors = 0;

    logic [63:0] sb[$];
    logic [63:0] sb4[$];

    mult_unit #(.WIDTH(32), .BITS_PER_CYCLE(1)) dut (
        .clk(clk), .reset_n(reset_n), .multstartE(multstartE), .signedE(signedE),
        .srcaE(srcaE), .srcbE(srcbE), .hiwriteE(hiwriteE), .lowriteE(lowriteE),
        .wdataE(wdataE), .hi(hi), .lo(lo), .pve(pve), .busy(busy)
    );

    mult_unit #(.WIDTH(32), .BITS_PER_CYCLE(4)) dut4 (
        .clk(clk), .reset_n(reset_n), .multstartE(start4), .signedE(signedE),
        .srcaE(srcaE), .srcbE(srcbE), .hiwriteE(hiwriteE), .lowriteE(lowriteE),
        .wdataE(wdataE), .hi(hi4), .lo(lo4), .pve(pve4), .busy(busy4)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish, got timeout required completion");
        $fatal(1, "[TB] watchdog expired");
    end

    function automatic logic [63:0] model(input logic s, input logic [31:0] a, input logic [31:0] b);
        logic signed [63:0] sa;
        logic signed [63:0] sbv;
        if (s) begin
            sa  = {{32{a[31]}}, a};
            sbv = {{32{b[31]}}, b};
            return sa * sbv;
        end
        return {32'b0, a} * {32'b0, b};
    endfunction

    task automatic driveStart(input logic s, input logic [31:0] a, input logic [31:0] b);
        @(negedge clk);
        multstartE = 1'b1;
        signedE    = s;
        srcaE      = a;
        srcbE      = b;
        sb.push_back(model(s, a, b));
        @(negedge clk);
        multstartE = 1'b0;
    endtask

    task automatic waitPve(output int lows);
        lows = 0;
        while (pve === 1'b0 && lows < 200) begin
            lows++;
            @(negedge clk);
        end
    endtask

    task automatic test_reset;
        logic [63:0] exp;
        exp = '0;
        reset_n = 1'b0; multstartE = 1'b0; start4 = 1'b0; signedE = 1'b0;
        srcaE = '0; srcbE = '0; hiwriteE = 1'b0; lowriteE = 1'b0; wdataE = '0;
        repeat (3) @(negedge clk);
        checks++;
        if ({hi, lo} !== exp) begin
            errors++; $display("[TB] FAIL reset_hilo got %h required %h", {hi, lo}, exp);
        end
        checks++;
        if ({pve, busy} !== 2'b10) begin
            errors++; $display("[TB] FAIL reset_flags got pve=%b busy=%b required pve=1 busy=0", pve, busy);
        end
        checks++;
        if ({hi4, lo4, pve4, busy4} !== {64'h0, 2'b10}) begin
            errors++; $display("[TB] FAIL reset_dut4 got %h %h %b %b required 0 0 1 0", hi4, lo4, pve4, busy4);
        end
        reset_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_multu_max;
        int lows;
        logic [63:0] exp;
        driveStart(1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        checks++;
        if (busy !== 1'b1) begin
            errors++; $display("[TB] FAIL busy_during_op got %b required 1", busy);
        end
        waitPve(lows);
        checks++;
        if (lows != 34) begin
            errors++; $display("[TB] FAIL latency_multu got %0d required 34", lows);
        end
        exp = sb.pop_front();
        checks++;
        if ({hi, lo} !== exp || exp !== 64'hFFFF_FFFE_0000_0001) begin
            errors++; $display("[TB] FAIL multu_max got %h required %h", {hi, lo}, 64'hFFFF_FFFE_0000_0001);
        end
        checks++;
        if ({pve, busy} !== 2'b10) begin
            errors++; $display("[TB] FAIL flags_after_done got pve=%b busy=%b required 1 0", pve, busy);
        end
    endtask

    task automatic test_signed;
        int lows;
        logic [63:0] exp;
        logic [31:0] av[4] = '{32'hFFFF_FFFD, 32'hFFFF_FFFD, 32'h8000_0000, 32'h8000_0000};
        logic [31:0] bv[4] = '{32'h0000_0007, 32'h0000_0007, 32'h8000_0000, 32'h0000_0001};
        logic        sv[4] = '{1'b1, 1'b0, 1'b1, 1'b1};
        for (int i = 0; i < 4; i++) begin
            driveStart(sv[i], av[i], bv[i]);
            waitPve(lows);
            checks++;
            if (lows != 34) begin
                errors++; $display("[TB] FAIL latency_signed_%0d got %0d required 34", i, lows);
            end
            exp = sb.pop_front();
            checks++;
            if ({hi, lo} !== exp) begin
                errors++; $display("[TB] FAIL product_signed_%0d got %h required %h", i, {hi, lo}, exp);
            end
        end
    endtask

    task automatic test_reset_abort;
        int lows;
        logic [63:0] exp;
        driveStart(1'b0, 32'h0000_1234, 32'h0000_0010);
        waitPve(lows);
        exp = sb.pop_front();
        checks++;
        if ({hi, lo} !== exp) begin
            errors++; $display("[TB] FAIL pre_abort_product got %h required %h", {hi, lo}, exp);
        end
        driveStart(1'b1, 32'h7654_3210, 32'hFEDC_BA98);
        repeat (9) @(negedge clk);
        reset_n = 1'b0;
        #1;
        sb.delete();
        checks++;
        if ({hi, lo, pve, busy} !== {64'h0, 2'b10}) begin
            errors++; $display("[TB] FAIL async_abort got hi=%h lo=%h pve=%b busy=%b required 0 0 1 0", hi, lo, pve, busy);
        end
        @(negedge clk);
        reset_n = 1'b1;
        driveStart(1'b0, 32'd5, 32'd6);
        waitPve(lows);
        exp = sb.pop_front();
        checks++;
        if ({hi, lo} !== exp || lows != 34) begin
            errors++; $display("[TB] FAIL post_abort_5x6 got %h lows=%0d required %h lows=34", {hi, lo}, lows, exp);
        end
    endtask

    task automatic test_mthi_mtlo;
        int lows;
        logic [63:0] exp;
        @(negedge clk);
        hiwriteE = 1'b1; lowriteE = 1'b1; wdataE = 32'hDEAD_BEEF;
        @(negedge clk);
        hiwriteE = 1'b0; lowriteE = 1'b0;
        checks++;
        if ({hi, lo} !== {32'hDEAD_BEEF, 32'hDEAD_BEEF}) begin
            errors++; $display("[TB] FAIL mt_both got %h required %h", {hi, lo}, {32'hDEAD_BEEF, 32'hDEAD_BEEF});
        end
        lowriteE = 1'b1; wdataE = 32'h0BAD_F00D;
        @(negedge clk);
        lowriteE = 1'b0;
        checks++;
        if ({hi, lo} !== {32'hDEAD_BEEF, 32'h0BAD_F00D}) begin
            errors++; $display("[TB] FAIL mtlo_only got %h required %h", {hi, lo}, {32'hDEAD_BEEF, 32'h0BAD_F00D});
        end
        driveStart(1'b0, 32'd3, 32'd4);
        lowriteE = 1'b1; wdataE = 32'h5555_5555;
        @(negedge clk);
        lowriteE = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if ({hi, lo} !== {32'hDEAD_BEEF, 32'h0BAD_F00D}) begin
            errors++; $display("[TB] FAIL mtlo_in_busy got %h required %h", {hi, lo}, {32'hDEAD_BEEF, 32'h0BAD_F00D});
        end
        waitPve(lows);
        exp = sb.pop_front();
        checks++;
        if ({hi, lo} !== exp) begin
            errors++; $display("[TB] FAIL done_overrides_mt got %h required %h", {hi, lo}, exp);
        end
        @(negedge clk);
        multstartE = 1'b1; signedE = 1'b0; srcaE = 32'd2; srcbE = 32'd3;
        hiwriteE = 1'b1; wdataE = 32'hCAFE_0000;
        sb.push_back(model(1'b0, 32'd2, 32'd3));
        @(negedge clk);
        multstartE = 1'b0; hiwriteE = 1'b0;
        checks++;
        if (hi !== 32'hCAFE_0000 || pve !== 1'b0) begin
            errors++; $display("[TB] FAIL start_with_mthi got hi=%h pve=%b required hi=cafe0000 pve=0", hi, pve);
        end
        waitPve(lows);
        exp = sb.pop_front();
        checks++;
        if ({hi, lo} !== exp) begin
            errors++; $display("[TB] FAIL start_with_mthi_result got %h required %h", {hi, lo}, exp);
        end
    endtask

    task automatic test_back_to_back;
        int lows;
        logic [63:0] exp;
        driveStart(1'b1, 32'h1234_5678, 32'h9ABC_DEF0);
        repeat (5) @(negedge clk);
        multstartE = 1'b1; signedE = 1'b0; srcaE = 32'h0000_0003; srcbE = 32'h0000_0003;
        @(negedge clk);
        multstartE = 1'b0;
        waitPve(lows);
        exp = sb.pop_front();
        checks++;
        if ({hi, lo} !== exp || lows != 28) begin
            errors++; $display("[TB] FAIL restart_ignored got %h lows=%0d required %h lows=28", {hi, lo}, lows, exp);
        end
        for (int i = 0; i < 3; i++) begin
            driveStart(i[0], $urandom, $urandom);
            waitPve(lows);
            exp = sb.pop_front();
            checks++;
            if ({hi, lo} !== exp || lows != 34) begin
                errors++; $display("[TB] FAIL back_to_back_%0d got %h lows=%0d required %h lows=34", i, {hi, lo}, lows, exp);
            end
        end
    endtask

    task automatic test_bpc4;
        int lows;
        logic [63:0] exp;
        logic [31:0] av[3] = '{32'hFFFF_FFFF, 32'h8000_0000, 32'hFFFF_FFFD};
        logic [31:0] bv[3] = '{32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0007};
        logic        sv[3] = '{1'b0, 1'b1, 1'b1};
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            start4 = 1'b1; signedE = sv[i]; srcaE = av[i]; srcbE = bv[i];
            sb4.push_back(model(sv[i], av[i], bv[i]));
            @(negedge clk);
            start4 = 1'b0;
            checks++;
            if (busy4 !== 1'b1) begin
                errors++; $display("[TB] FAIL bpc4_busy_%0d got %b required 1", i, busy4);
            end
            lows = 0;
            while (pve4 === 1'b0 && lows < 200) begin
                lows++;
                @(negedge clk);
            end
            checks++;
            if (lows != 10) begin
                errors++; $display("[TB] FAIL bpc4_latency_%0d got %0d required 10", i, lows);
            end
            exp = sb4.pop_front();
            checks++;
            if ({hi4, lo4} !== exp) begin
                errors++; $display("[TB] FAIL bpc4_product_%0d got %h required %h", i, {hi4, lo4}, exp);
            end
        end
    endtask

    initial begin
        test_reset();
        test_multu_max();
        test_signed();
        test_reset_abort();
        test_mthi_mtlo();
        test_back_to_back();
        test_bpc4();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
